rvj1_ifu: RTL
=============

Name: rvj1_ifu

Overview:
Instruction fetch unit for the rvj1 core; the producing end of the ifu_instr/ifu_valid/ifu_ready handshake consumed by the decoder. Issues word fetches on a request/grant/rvalid instruction-memory port, buffers returned words in a FIFO and presents them in program order. Redirects on jumps from the execute stage, flushing buffered words and discarding in-flight responses.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC after reset; bits [1:0] must be 0.
FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 2. Also the cap on outstanding memory requests.

Ports:
clk_i  in  1  clock; all state on rising edge.
rst_i  in  1  asynchronous active-high reset.
instr_req_o  out  1  fetch request.
instr_addr_o  out  XLEN  fetch word address; [1:0] always 0.
instr_gnt_i  in  1  request accepted this cycle.
instr_rvalid_i  in  1  response valid; in order, at least 1 cycle after its grant.
instr_rdata_i  in  XLEN  response data.
ifu_instr_o  out  XLEN  instruction at FIFO head.
ifu_valid_o  out  1  FIFO non-empty.
ifu_ready_i  in  1  decoder accepts the head this cycle.
jmp_i  in  1  redirect strobe, one cycle.
jmp_addr_i  in  XLEN  redirect target; [1:0] ignored and treated as 0.

Behaviour:
- Reset values: instr_req_o=0, instr_addr_o=BOOT_ADDR, ifu_valid_o=0, ifu_instr_o=0. FIFO, counters and discard count are cleared. State is FETCH after reset. Reset asserted mid-operation aborts everything; responses that arrive later with nothing outstanding are ignored.
- The pop occurs when ifu_valid_o and ifu_ready_i are both high. ifu_instr_o and ifu_valid_o come from registered FIFO state only, with no combinational path from any input.
- The push occurs when instr_rvalid_i is high and discard_cnt is 0. The word appears at the outputs no earlier than the cycle after instr_rvalid_i.
- Credit rule: a request is issued only if fifo_count + outstanding < FIFO_DEPTH. outstanding counts granted requests without a response, including those marked for discard. Push and pop in the same cycle leave fifo_count unchanged. A full FIFO is never written.
- Grant: instr_addr_o advances by 4 on the grant edge and wraps modulo 2^32. A request that is not granted keeps instr_req_o and instr_addr_o stable until it is granted.
- FSM states:
  - FETCH: instr_req_o = credit available.
  - JMP_PEND: entered on jmp_i while instr_req_o=1 and instr_gnt_i=0. The target is saved in jmp_pend_addr. The request stays stable until granted. On grant, that request is also marked for discard, instr_addr_o loads jmp_pend_addr, and the FSM returns to FETCH.
- Jump in FETCH, or with a grant in the same cycle:
  - The FIFO is flushed on the next edge; a same-cycle pop or push is overridden.
  - instr_addr_o loads the target.
  - discard_cnt loads outstanding, plus 1 if granted this cycle, minus 1 if rvalid this cycle.
  - ifu_valid_o is 0 in the following cycle.
- A response with discard_cnt>0 decrements discard_cnt and outstanding and is never pushed.
- Jump during JMP_PEND: only jmp_pend_addr is overwritten.
- Jump latency: with zero-wait memory (grant same cycle, rvalid next cycle), the target word is valid 3 cycles after jmp_i. The redirected request goes out the cycle after jmp_i.

Optional Feature:
RVJ1_IFU_PC_OUT_EN.
- Defined: adds output ifu_pc_o (XLEN). Each FIFO entry stores the fetch address alongside the data, taken from a parallel in-flight address queue of FIFO_DEPTH entries. ifu_pc_o is the PC of the head entry and resets to BOOT_ADDR.
- Undefined: no port, no PC storage.
- Fetch behaviour is otherwise identical.

Test Plan:
- Reset, BOOT_ADDR=0x100, zero-wait memory, ifu_ready_i=1 -> addresses 0x100,0x104,0x108 issued on consecutive cycles; ifu_valid_o first high 2 cycles after reset release, carrying mem[0x100]; thereafter one instruction per cycle.
- ifu_ready_i=0, FIFO_DEPTH=4 -> exactly 4 grants, then instr_req_o=0; after ready rises and 1 pop, one new request is issued; order is preserved.
- Grant withheld 3 cycles -> instr_req_o and instr_addr_o stay constant; instr_addr_o advances only on the grant edge.
- Jump to 0x200 with 2 responses in flight (rvalid delay 2) -> both responses dropped, FIFO empties, the first valid instruction is mem[0x200]; PC trace is ...,0x200,0x204.
- Jump with jmp_addr_i=0x303 while a request waits for grant -> JMP_PEND; the old request's data is dropped; the next request goes to 0x300.
- Jump in the same cycle as a pop and an rvalid -> both are overridden; ifu_valid_o=0 the next cycle; with RVJ1_IFU_PC_OUT_EN defined, ifu_pc_o equals the address for every delivered word.

Source files
------------

// File: rtl/rvj1_ifu.sv
// rtl/rvj1_ifu.sv - rvj1 instruction fetch unit: credit-limited word fetch, in-order buffer, jump redirect
//
// Optional feature macro: RVJ1_IFU_PC_OUT_EN
//   defined   -> adds output ifu_pc_o, the fetch address of the buffered head word
//   undefined -> no PC port and no PC storage
//
// Parameters:
//   BOOT_ADDR   PC after reset, word aligned
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2); also caps outstanding requests
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   instr_req_o        fetch request, held stable until granted
//   instr_addr_o       fetch word address
//   instr_gnt_i        request accepted this cycle
//   instr_rvalid_i     in-order response valid
//   instr_rdata_i      response data
//   ifu_instr_o        instruction at buffer head
//   ifu_valid_o        buffer non-empty
//   ifu_ready_i        decoder takes the head this cycle
//   jmp_i, jmp_addr_i  one-cycle redirect strobe and target
//   ifu_pc_o           head PC (only with RVJ1_IFU_PC_OUT_EN)

module rvj1_ifu #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic [31:0] ifu_instr_o,
    output logic        ifu_valid_o,
    input  logic        ifu_ready_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_addr_i
`ifdef RVJ1_IFU_PC_OUT_EN
    ,
    output logic [31:0] ifu_pc_o
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

    typedef enum logic [0:0] {
        S_FETCH    = 1'b0,
        S_JMP_PEND = 1'b1
    } state_t;

    state_t        r_state;
    logic [31:0]   r_addr;
    logic [31:0]   r_jmp_pend_addr;
    logic [31:0]   r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;

    logic [31:0]   w_tgt;
    logic [CW:0]   w_inflight;
    logic          w_credit;
    logic          w_req;
    logic          w_gnt;
    logic          w_resp;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_flush;
    logic [CW-1:0] w_outst_nxt;

    assign w_tgt = jmp_addr_i & 32'hFFFF_FFFC;

    // Buffered words plus words still owed by memory must fit in the buffer,
    // so every response can always be pushed without a full check.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outst};
    assign w_credit   = (w_inflight < DEPTH_W);

    // Credit can only grow while a request waits (pops, responses, flushes),
    // so a raised request stays raised until granted. JMP_PEND holds it explicitly.
    assign w_req = !rst_i && ((r_state == S_JMP_PEND) || w_credit);
    assign w_gnt = w_req && instr_gnt_i;

    // Responses with nothing outstanding are leftovers from before a reset.
    assign w_resp = instr_rvalid_i && (r_outst != '0);
    assign w_push = w_resp && (r_discard == '0);
    assign w_drop = w_resp && (r_discard != '0);
    assign w_pop  = ifu_valid_o && ifu_ready_i;

    // A jump seen in FETCH flushes at once (even if the request is stalled and
    // the FSM parks in JMP_PEND); the stalled request flushes again on its grant,
    // which also catches a newer jump arriving on that same grant cycle.
    assign w_flush = (jmp_i && (r_state == S_FETCH)) || (w_gnt && (r_state == S_JMP_PEND));

    assign w_outst_nxt = r_outst + {{(CW-1){1'b0}}, w_gnt} - {{(CW-1){1'b0}}, w_resp};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= S_FETCH;
            r_addr          <= BOOT_ADDR;
            r_jmp_pend_addr <= BOOT_ADDR;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_outst         <= '0;
            r_discard       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_data[i] <= '0;
            end
        end else begin
            r_outst <= w_outst_nxt;

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_data[r_wptr] <= instr_rdata_i;
                    r_wptr              <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            // On a redirect everything still owed by memory is wrong-path,
            // including a request granted on the redirect cycle itself.
            if (w_flush) begin
                r_discard <= w_outst_nxt;
            end else if (w_drop) begin
                r_discard <= r_discard - 1'b1;
            end

            case (r_state)
                S_FETCH: begin
                    if (jmp_i && w_req && !instr_gnt_i) begin
                        r_state         <= S_JMP_PEND;
                        r_jmp_pend_addr <= w_tgt;
                    end else if (jmp_i) begin
                        r_addr <= w_tgt;
                    end else if (w_gnt) begin
                        r_addr <= r_addr + 32'd4;
                    end
                end
                S_JMP_PEND: begin
                    if (w_gnt) begin
                        r_state <= S_FETCH;
                        r_addr  <= jmp_i ? w_tgt : r_jmp_pend_addr;
                    end else if (jmp_i) begin
                        r_jmp_pend_addr <= w_tgt;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign instr_req_o  = w_req;
    assign instr_addr_o = r_addr;
    assign ifu_instr_o  = r_fifo_data[r_rptr];
    assign ifu_valid_o  = (r_count != '0);

`ifdef RVJ1_IFU_PC_OUT_EN
    // Address of every granted request, consumed in response order
    // (discarded responses consume their entry too).
    logic [31:0]   r_aq [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc [FIFO_DEPTH];
    logic [AW-1:0] r_aq_wptr;
    logic [AW-1:0] r_aq_rptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aq_wptr <= '0;
            r_aq_rptr <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_aq[i]      <= BOOT_ADDR;
                r_fifo_pc[i] <= BOOT_ADDR;
            end
        end else begin
            if (w_gnt) begin
                r_aq[r_aq_wptr] <= r_addr;
                r_aq_wptr       <= r_aq_wptr + 1'b1;
            end
            if (w_resp) begin
                r_aq_rptr <= r_aq_rptr + 1'b1;
            end
            if (w_push && !w_flush) begin
                r_fifo_pc[r_wptr] <= r_aq[r_aq_rptr];
            end
        end
    end

    assign ifu_pc_o = r_fifo_pc[r_rptr];
`endif

endmodule
